read_resp_arbiter: RTL and testbench

//  Master-side collector for AXI read-data (R) streams: merges the per-slave R streams

---
 rtl/read_resp_arbiter.sv | 138 +++++++++++++
 tb/tb_read_resp_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_resp_arbiter.sv
// read_resp_arbiter
// Merges the per-slave AXI R streams for one master into that master's single
// R channel. Arbitration is round-robin at burst granularity: once a slave is
// granted it keeps the channel until its rlast beat transfers, so bursts from
// different slaves never interleave.
module read_resp_arbiter #(
   parameter int NUM_SLAVES = 3,
   parameter int ID_W       = 4,
   parameter int DATA_W     = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_SLAVES*ID_W-1:0]   s_axi_r_rid,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_axi_r_rdata,
   input  logic [NUM_SLAVES*2-1:0]      s_axi_r_rresp,
   input  logic [NUM_SLAVES-1:0]        s_axi_r_rlast,
   input  logic [NUM_SLAVES-1:0]        s_axi_r_valid,
   output logic [NUM_SLAVES-1:0]        s_axi_r_ready,
   output logic [ID_W-1:0]              m_axi_r_rid,
   output logic [DATA_W-1:0]            m_axi_r_rdata,
   output logic [1:0]                   m_axi_r_rresp,
   output logic                         m_axi_r_rlast,
   output logic                         m_axi_r_valid,
   input  logic                         m_axi_r_ready,
   output logic                         err_seen
);

   // A single slave still needs a 1-bit index so the grant register exists.
   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLAVES - 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]       state_reg, state_next;
   logic [IDX_W-1:0] grant_reg, grant_next;
   logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic             err_seen_reg, err_seen_next;

   // Per-slave views of the packed input buses.
   logic [ID_W-1:0]   rid_arr   [NUM_SLAVES];
   logic [DATA_W-1:0] rdata_arr [NUM_SLAVES];
   logic [1:0]        rresp_arr [NUM_SLAVES];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_unpack
         assign rid_arr[gi]   = s_axi_r_rid[gi*ID_W +: ID_W];
         assign rdata_arr[gi] = s_axi_r_rdata[gi*DATA_W +: DATA_W];
         assign rresp_arr[gi] = s_axi_r_rresp[gi*2 +: 2];
      end
   endgenerate

   logic             locked;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] scan_idx;
   logic             beat_xfer;

   assign locked    = (state_reg == ST_LOCKED);
   assign beat_xfer = m_axi_r_valid && m_axi_r_ready;
   assign err_seen  = err_seen_reg;

   // Round-robin scan: first valid slave starting at rr_ptr, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         scan_idx = IDX_W'((int'(rr_ptr_reg) + k) % NUM_SLAVES);
         if (!pick_found && s_axi_r_valid[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   // Master-side mux of the granted slave; everything is quiet while idle.
   always_comb begin
      m_axi_r_valid = 1'b0;
      m_axi_r_rid   = '0;
      m_axi_r_rdata = '0;
      m_axi_r_rresp = '0;
      m_axi_r_rlast = 1'b0;
      s_axi_r_ready = '0;
      if (locked) begin
         m_axi_r_valid            = s_axi_r_valid[grant_reg];
         m_axi_r_rid              = rid_arr[grant_reg];
         m_axi_r_rdata            = rdata_arr[grant_reg];
         m_axi_r_rresp            = rresp_arr[grant_reg];
         m_axi_r_rlast            = s_axi_r_rlast[grant_reg];
         s_axi_r_ready[grant_reg] = m_axi_r_ready;
      end
   end

   // Next-state: lock on a pick in IDLE, release and advance rr_ptr on rlast.
   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      rr_ptr_next   = rr_ptr_reg;
      err_seen_next = err_seen_reg;
      case (state_reg)
         ST_IDLE: begin
            if (pick_found) begin
               grant_next = pick_idx;
               state_next = ST_LOCKED;
            end
         end
         default: begin
            if (beat_xfer) begin
               if (m_axi_r_rresp[1]) begin
                  err_seen_next = 1'b1;
               end
               if (m_axi_r_rlast) begin
                  state_next  = ST_IDLE;
                  rr_ptr_next = (grant_reg == LAST_IDX) ? '0 : grant_reg + 1'b1;
               end
            end
         end
      endcase
   end

   // State registers; reset abandons any burst in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         grant_reg    <= '0;
         rr_ptr_reg   <= '0;
         err_seen_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         rr_ptr_reg   <= rr_ptr_next;
         err_seen_reg <= err_seen_next;
      end
   end

endmodule

// File: tb/tb_read_resp_arbiter.sv
// Bench for read_resp_arbiter: queue-driven slave models, a burst-level
// ownership model checked every cycle, and directed scenarios with literal
// expectations on the resulting transfer log.
module tb_read_resp_arbiter;

   localparam int NS = 3;
   localparam int IW = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [NS*IW-1:0] s_axi_r_rid;
   logic [NS*DW-1:0] s_axi_r_rdata;
   logic [NS*2-1:0]  s_axi_r_rresp;
   logic [NS-1:0]    s_axi_r_rlast;
   logic [NS-1:0]    s_axi_r_valid;
   logic [NS-1:0]    s_axi_r_ready;
   logic [IW-1:0]    m_axi_r_rid;
   logic [DW-1:0]    m_axi_r_rdata;
   logic [1:0]       m_axi_r_rresp;
   logic             m_axi_r_rlast;
   logic             m_axi_r_valid;
   logic             m_axi_r_ready;
   logic             err_seen;

   read_resp_arbiter #(.NUM_SLAVES(NS), .ID_W(IW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .s_axi_r_rid(s_axi_r_rid), .s_axi_r_rdata(s_axi_r_rdata),
      .s_axi_r_rresp(s_axi_r_rresp), .s_axi_r_rlast(s_axi_r_rlast),
      .s_axi_r_valid(s_axi_r_valid), .s_axi_r_ready(s_axi_r_ready),
      .m_axi_r_rid(m_axi_r_rid), .m_axi_r_rdata(m_axi_r_rdata),
      .m_axi_r_rresp(m_axi_r_rresp), .m_axi_r_rlast(m_axi_r_rlast),
      .m_axi_r_valid(m_axi_r_valid), .m_axi_r_ready(m_axi_r_ready),
      .err_seen(err_seen)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } beat_t;

   typedef struct {
      int            slave;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
      int            cyc;
   } xfer_t;

   beat_t sq [NS][$];    // pending beats per slave
   xfer_t xlog [$];      // transfers accepted by the master, per the model
   bit    hold [NS];     // forces a slave's valid low while set

   // Burst-level model: who owns the channel, who has priority next, sticky error.
   int owner = -1;
   int prio  = 0;
   bit err_m = 1'b0;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int k, input int n, input logic [DW-1:0] base,
                       input logic [1:0] resp, input logic [IW-1:0] id);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.id   = id;
         b.data = base + DW'(i);
         b.resp = resp;
         b.last = (i == n - 1);
         sq[k].push_back(b);
      end
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < NS; k++) begin
         if (sq[k].size() > 0 && !hold[k]) begin
            s_axi_r_valid[k]          = 1'b1;
            s_axi_r_rid[k*IW +: IW]   = sq[k][0].id;
            s_axi_r_rdata[k*DW +: DW] = sq[k][0].data;
            s_axi_r_rresp[k*2 +: 2]   = sq[k][0].resp;
            s_axi_r_rlast[k]          = sq[k][0].last;
         end else begin
            s_axi_r_valid[k]          = 1'b0;
            s_axi_r_rid[k*IW +: IW]   = '0;
            s_axi_r_rdata[k*DW +: DW] = '0;
            s_axi_r_rresp[k*2 +: 2]   = '0;
            s_axi_r_rlast[k]          = 1'b0;
         end
      end
   endtask

   // One clock cycle: drive, compare against the model, advance model at the edge.
   task automatic step();
      logic [NS-1:0] exp_ready;
      bit    exp_valid;
      bit    xfer;
      int    nxt;
      beat_t hb;
      drive_inputs();
      #1;
      exp_ready = '0;
      exp_valid = 1'b0;
      hb.id = '0; hb.data = '0; hb.resp = '0; hb.last = 1'b0;
      if (owner >= 0) begin
         exp_valid        = s_axi_r_valid[owner];
         exp_ready[owner] = m_axi_r_ready;
      end
      chk("m_valid", m_axi_r_valid, exp_valid);
      chk("s_ready", s_axi_r_ready, exp_ready);
      chk("err_seen", err_seen, err_m);
      if (exp_valid) begin
         hb = sq[owner][0];
         chk("m_rid", m_axi_r_rid, hb.id);
         chk("m_rdata", m_axi_r_rdata, hb.data);
         chk("m_rresp", m_axi_r_rresp, hb.resp);
         chk("m_rlast", m_axi_r_rlast, hb.last);
         if (prev_stall) chk("stall_stable", m_axi_r_rdata, prev_data);
      end
      xfer = exp_valid && m_axi_r_ready && !rst;
      nxt  = -1;
      if (owner < 0) begin
         for (int i = 0; i < NS; i++) begin
            int c;
            c = (prio + i) % NS;
            if (nxt < 0 && s_axi_r_valid[c]) nxt = c;
         end
      end
      @(posedge clk);
      if (rst) begin
         owner = -1; prio = 0; err_m = 1'b0; prev_stall = 1'b0;
         for (int k = 0; k < NS; k++) sq[k].delete();
      end else if (owner < 0) begin
         owner = nxt;
         prev_stall = 1'b0;
      end else begin
         prev_stall = exp_valid && !m_axi_r_ready;
         prev_data  = hb.data;
         if (xfer) begin
            xlog.push_back('{owner, hb.data, hb.resp, hb.last, cyc});
            void'(sq[owner].pop_front());
            if (hb.resp[1]) err_m = 1'b1;
            if (hb.last) begin
               prio  = (owner + 1) % NS;
               owner = -1;
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   function automatic bit busy();
      bit b;
      b = (owner >= 0);
      for (int k = 0; k < NS; k++) if (sq[k].size() > 0) b = 1'b1;
      return b;
   endfunction

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while (busy() && n < maxc) begin
         step();
         n++;
      end
      if (busy()) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: still busy after %0d cycles, required idle", maxc);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      rst = 1'b1;
      m_axi_r_ready = 1'b0;
      for (int k = 0; k < NS; k++) hold[k] = 1'b0;
      drive_inputs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state pinned by literals.
      chk("rst_valid", m_axi_r_valid, 0);
      chk("rst_ready", s_axi_r_ready, 0);
      chk("rst_rid", m_axi_r_rid, 0);
      chk("rst_rdata", m_axi_r_rdata, 0);
      chk("rst_rresp", m_axi_r_rresp, 0);
      chk("rst_rlast", m_axi_r_rlast, 0);
      chk("rst_err", err_seen, 0);
      step();

      // 1: single 4-beat burst from slave 0, full throughput.
      m_axi_r_ready = 1'b1;
      xlog.delete();
      start = cyc;
      push(0, 4, 32'hA0, 2'b00, 4'h3);
      drain(20);
      step();
      chk("t1_count", xlog.size(), 4);
      for (int i = 0; i < 4 && i < xlog.size(); i++) begin
         chk("t1_data", xlog[i].data, 32'hA0 + i);
         chk("t1_slave", xlog[i].slave, 0);
      end
      if (xlog.size() == 4) begin
         chk("t1_latency", xlog[0].cyc, start + 1);
         chk("t1_lastcyc", xlog[3].cyc, start + 4);
         chk("t1_rlast", xlog[3].last, 1);
      end

      // 2: slaves 0 and 1 together; slave 0 first, one bubble, then slave 1.
      do_reset();
      xlog.delete();
      push(0, 2, 32'hB0, 2'b00, 4'h1);
      push(1, 2, 32'hC0, 2'b00, 4'h2);
      drain(20);
      chk("t2_count", xlog.size(), 4);
      if (xlog.size() == 4) begin
         chk("t2_s0", xlog[0].slave, 0);
         chk("t2_s1", xlog[1].slave, 0);
         chk("t2_s2", xlog[2].slave, 1);
         chk("t2_s3", xlog[3].slave, 1);
         chk("t2_d2", xlog[2].data, 32'hC0);
         chk("t2_bubble", xlog[2].cyc, xlog[1].cyc + 2);
      end

      // 3: continuous single-beat bursts on all slaves -> 0,1,2,0,1,2.
      do_reset();
      xlog.delete();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < NS; k++)
            push(k, 1, 32'h300 + 32'(r * 16 + k), 2'b00, 4'(k));
      drain(30);
      chk("t3_count", xlog.size(), 6);
      for (int i = 0; i < 6 && i < xlog.size(); i++)
         chk("t3_order", xlog[i].slave, i % 3);

      // 4: slave 2 burst under master backpressure 1,0,0,1.
      xlog.delete();
      push(2, 4, 32'hD0, 2'b01, 4'h7);
      m_axi_r_ready = 1'b1;
      step();
      m_axi_r_ready = 1'b1; step();
      m_axi_r_ready = 1'b0; step();
      m_axi_r_ready = 1'b0; step();
      m_axi_r_ready = 1'b1; step();
      drain(20);
      chk("t4_count", xlog.size(), 4);
      for (int i = 0; i < 4 && i < xlog.size(); i++) begin
         chk("t4_data", xlog[i].data, 32'hD0 + i);
         chk("t4_slave", xlog[i].slave, 2);
      end

      // 5: error response forwarded, sticky until reset.
      xlog.delete();
      push(1, 1, 32'h55, 2'b10, 4'h5);
      drain(10);
      chk("t5_err_set", err_seen, 1);
      if (xlog.size() == 1) chk("t5_resp", xlog[0].resp, 2'b10);
      step(); step(); step();
      chk("t5_err_hold", err_seen, 1);
      do_reset();
      chk("t5_err_clr", err_seen, 0);

      // 6: reset during beat 2 of a slave 0 burst, then a fresh slave 2 burst.
      xlog.delete();
      push(0, 4, 32'hE0, 2'b00, 4'h0);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_valid", m_axi_r_valid, 0);
      chk("t6_ready", s_axi_r_ready, 0);
      push(2, 2, 32'hF0, 2'b00, 4'h9);
      drain(10);
      chk("t6_count", xlog.size(), 3);
      if (xlog.size() == 3) begin
         chk("t6_first", xlog[0].data, 32'hE0);
         chk("t6_slave", xlog[1].slave, 2);
         chk("t6_data", xlog[2].data, 32'hF1);
      end

      // 7: granted slave drops valid mid-burst; no re-arbitration to slave 0.
      do_reset();
      xlog.delete();
      push(1, 2, 32'h70, 2'b00, 4'h4);
      step();
      step();
      push(0, 1, 32'h80, 2'b00, 4'h8);
      hold[1] = 1'b1;
      step();
      step();
      hold[1] = 1'b0;
      drain(10);
      chk("t7_count", xlog.size(), 3);
      if (xlog.size() == 3) begin
         chk("t7_o0", xlog[0].slave, 1);
         chk("t7_o1", xlog[1].slave, 1);
         chk("t7_o2", xlog[2].slave, 0);
         chk("t7_d1", xlog[1].data, 32'h71);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
